// File: rtl/plab5_mcore_tdm_pkg.sv
//------------------------------------------------------------------------------
// plab5_mcore_tdm_pkg
// Shared FSM encodings, domain constants and memory message widths.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

package plab5_mcore_tdm_pkg;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_WAIT = 1'b1
   } arb_state_e;

   localparam logic D0 = 1'b0;
   localparam logic D1 = 1'b1;

   // Memory request: type(3) + opaque + addr + len + data
   function automatic int vc_mem_req_nbits(input int o, input int a, input int d);
      return 3 + o + a + $clog2(d/8) + d;
   endfunction

   // Memory response: type(3) + opaque + test(2) + len + data
   function automatic int vc_mem_resp_nbits(input int o, input int d);
      return 3 + o + 2 + $clog2(d/8) + d;
   endfunction

endpackage

`default_nettype wire

// File: rtl/plab5_mcore_tdm_slot_timer.sv
//------------------------------------------------------------------------------
// plab5_mcore_tdm_slot_timer
// Free-running slot counter: owner toggles every p_slot_len cycles.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module plab5_mcore_tdm_slot_timer #(
   parameter int p_slot_len = 8,
   parameter int p_guard    = 3
)(
   input  logic clk,
   input  logic reset,
   output logic owner_o,
   output logic win_o
);

   localparam int            CW         = $clog2(p_slot_len + 1);
   localparam logic [CW-1:0] C_LAST     = CW'(p_slot_len - 1);
   localparam logic [CW-1:0] C_WIN_END  = CW'(p_slot_len - p_guard);

   logic [CW-1:0] cnt_q, cnt_d;
   logic          owner_q, owner_d;

   // Never looks at traffic, so neither domain can perturb the schedule
   always_comb begin
      cnt_d   = cnt_q + CW'(1);
      owner_d = owner_q;
      if (cnt_q == C_LAST) begin
         cnt_d   = '0;
         owner_d = ~owner_q;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt_q   <= '0;
         owner_q <= 1'b0;
      end else begin
         cnt_q   <= cnt_d;
         owner_q <= owner_d;
      end
   end

   assign owner_o = owner_q;
   assign win_o   = (cnt_q < C_WIN_END);

endmodule

`default_nettype wire

// File: rtl/plab5_mcore_tdm_mem_arb.sv
//------------------------------------------------------------------------------
// plab5_mcore_tdm_mem_arb
// Time-division memory arbiter between two security domains, one request in flight.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module plab5_mcore_tdm_mem_arb
   import plab5_mcore_tdm_pkg::*;
#(
   parameter int  p_opaque_nbits = 8,
   parameter int  p_addr_nbits   = 32,
   parameter int  p_data_nbits   = 128,
   parameter int  p_slot_len     = 8,
   parameter int  p_guard        = 3,
   localparam int c_memreq_nbits  = vc_mem_req_nbits(p_opaque_nbits, p_addr_nbits, p_data_nbits),
   localparam int c_memresp_nbits = vc_mem_resp_nbits(p_opaque_nbits, p_data_nbits)
)(
   input  logic                                  clk,
   input  logic                                  reset,

   input  logic [c_memreq_nbits-1:0]             req0_msg,
   input  logic                                  req0_val,
   output logic                                  req0_rdy,
   input  logic [c_memreq_nbits-1:0]             req1_msg,
   input  logic                                  req1_val,
   output logic                                  req1_rdy,

   output logic [c_memresp_nbits-1:0]            resp0_msg,
   output logic                                  resp0_val,
   input  logic                                  resp0_rdy,
   output logic [c_memresp_nbits-1:0]            resp1_msg,
   output logic                                  resp1_val,
   input  logic                                  resp1_rdy,

   output logic [c_memreq_nbits-p_data_nbits-1:0] memreq_control,
   output logic [p_data_nbits-1:0]               memreq_data,
   output logic                                  memreq_domain,
   output logic                                  memreq_val,
   input  logic                                  memreq_rdy,

   input  logic [c_memresp_nbits-p_data_nbits-1:0] memresp_control,
   input  logic [p_data_nbits-1:0]               memresp_data,
   input  logic                                  memresp_domain,
   input  logic                                  memresp_val,
   output logic                                  memresp_rdy,

   output logic                                  slot_owner,
   output logic                                  violation
);

   logic       owner, win;
   arb_state_e state_q, state_d;
   logic       tag_q, tag_d;
   logic       violation_q, violation_d;
   logic [c_memreq_nbits-1:0] sel_msg;
   logic       sel_val;
   logic       resp_fire;

   plab5_mcore_tdm_slot_timer #(
      .p_slot_len (p_slot_len),
      .p_guard    (p_guard)
   ) u_timer (
      .clk     (clk),
      .reset   (reset),
      .owner_o (owner),
      .win_o   (win)
   );

   assign sel_msg        = (owner == D1) ? req1_msg : req0_msg;
   assign sel_val        = (owner == D1) ? req1_val : req0_val;
   assign memreq_control = sel_msg[c_memreq_nbits-1:p_data_nbits];
   assign memreq_data    = sel_msg[p_data_nbits-1:0];
   assign memreq_domain  = owner;
   assign resp0_msg      = {memresp_control, memresp_data};
   assign resp1_msg      = {memresp_control, memresp_data};
   assign slot_owner     = owner;
   assign violation      = violation_q;

   always_comb begin
      state_d     = state_q;
      tag_d       = tag_q;
      req0_rdy    = 1'b0;
      req1_rdy    = 1'b0;
      memreq_val  = 1'b0;
      resp0_val   = 1'b0;
      resp1_val   = 1'b0;
      memresp_rdy = 1'b0;
      resp_fire   = 1'b0;
      violation_d = violation_q;
      case (state_q)
         ST_IDLE: begin
            memreq_val = sel_val & win;
            req0_rdy   = (owner == D0) & memreq_rdy & win;
            req1_rdy   = (owner == D1) & memreq_rdy & win;
            if (memreq_val && memreq_rdy) begin
               tag_d   = owner;
               state_d = ST_WAIT;
            end
            // A response with nothing outstanding is left unconsumed
            if (memresp_val) violation_d = 1'b1;
         end
         ST_WAIT: begin
            memresp_rdy = (tag_q == D1) ? resp1_rdy : resp0_rdy;
            resp0_val   = memresp_val & (tag_q == D0);
            resp1_val   = memresp_val & (tag_q == D1);
            resp_fire   = memresp_val & memresp_rdy;
            if (resp_fire) begin
               state_d = ST_IDLE;
               if ((owner != tag_q) || (memresp_domain != tag_q)) violation_d = 1'b1;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= ST_IDLE;
         tag_q       <= D0;
         violation_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         tag_q       <= tag_d;
         violation_q <= violation_d;
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_plab5_mcore_tdm_mem_arb.sv
//------------------------------------------------------------------------------
// tb_plab5_mcore_tdm_mem_arb
// Directed self-checking bench, p_slot_len=8, p_guard=3.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_plab5_mcore_tdm_mem_arb;
   import plab5_mcore_tdm_pkg::*;

   localparam int DW     = 128;
   localparam int REQ_W  = vc_mem_req_nbits(8, 32, DW);
   localparam int RESP_W = vc_mem_resp_nbits(8, DW);

   logic clk = 1'b0;
   logic reset = 1'b1;
   logic [REQ_W-1:0]  req0_msg, req1_msg;
   logic              req0_val, req1_val, req0_rdy, req1_rdy;
   logic [RESP_W-1:0] resp0_msg, resp1_msg;
   logic              resp0_val, resp1_val, resp0_rdy, resp1_rdy;
   logic [REQ_W-DW-1:0]  memreq_control;
   logic [DW-1:0]        memreq_data;
   logic                 memreq_domain, memreq_val, memreq_rdy;
   logic [RESP_W-DW-1:0] memresp_control;
   logic [DW-1:0]        memresp_data;
   logic                 memresp_domain, memresp_val, memresp_rdy;
   logic                 slot_owner, violation;

   plab5_mcore_tdm_mem_arb #(
      .p_opaque_nbits (8), .p_addr_nbits (32), .p_data_nbits (DW),
      .p_slot_len (8), .p_guard (3)
   ) dut (
      .clk (clk), .reset (reset),
      .req0_msg (req0_msg), .req0_val (req0_val), .req0_rdy (req0_rdy),
      .req1_msg (req1_msg), .req1_val (req1_val), .req1_rdy (req1_rdy),
      .resp0_msg (resp0_msg), .resp0_val (resp0_val), .resp0_rdy (resp0_rdy),
      .resp1_msg (resp1_msg), .resp1_val (resp1_val), .resp1_rdy (resp1_rdy),
      .memreq_control (memreq_control), .memreq_data (memreq_data),
      .memreq_domain (memreq_domain), .memreq_val (memreq_val), .memreq_rdy (memreq_rdy),
      .memresp_control (memresp_control), .memresp_data (memresp_data),
      .memresp_domain (memresp_domain), .memresp_val (memresp_val), .memresp_rdy (memresp_rdy),
      .slot_owner (slot_owner), .violation (violation)
   );

   always #5 clk = ~clk;

   int n_chk  = 0;
   int n_pass = 0;

   task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   task automatic clear_inputs();
      req0_msg = '0; req1_msg = '0; req0_val = 1'b0; req1_val = 1'b0;
      resp0_rdy = 1'b0; resp1_rdy = 1'b0; memreq_rdy = 1'b0;
      memresp_control = '0; memresp_data = '0; memresp_domain = 1'b0; memresp_val = 1'b0;
   endtask

   // Returns at the start of cycle 0 (cnt=0, owner=0)
   task automatic do_reset();
      @(negedge clk);
      reset = 1'b1;
      clear_inputs();
      @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic steps(input int n);
      for (int i = 0; i < n; i++) @(negedge clk);
   endtask

   task automatic run_sat(input logic busy0, output logic [31:0] own,
                          output logic [31:0] iss0, output logic [31:0] iss1,
                          output logic viol);
      logic pend, pdom, fire;
      do_reset();
      memreq_rdy = 1'b1; resp0_rdy = 1'b1; resp1_rdy = 1'b1;
      req0_val = busy0; req1_val = 1'b1;
      pend = 1'b0; pdom = 1'b0;
      own = '0; iss0 = '0; iss1 = '0;
      for (int k = 0; k < 32; k++) begin
         memresp_val = pend; memresp_domain = pdom;
         #1;
         own[k] = slot_owner;
         fire   = memreq_val & memreq_rdy;
         if (fire && memreq_domain == D0) iss0[k] = 1'b1;
         if (fire && memreq_domain == D1) iss1[k] = 1'b1;
         pend = fire; pdom = memreq_domain;
         @(negedge clk);
      end
      viol = violation;
      clear_inputs();
   endtask

   logic [46:0]  ctl;
   logic [127:0] dat;
   logic [16:0]  rctl;
   logic [127:0] rdat;
   logic [31:0]  ownA, ownB, i0A, i0B, i1A, i1B;
   logic         vA, vB;

   initial begin
      clear_inputs();

      // Reset state and a simple domain-0 round trip
      do_reset();
      memreq_rdy = 1'b1;
      #1;
      check("rst_memreq_val", memreq_val, 0);
      check("rst_req0_rdy",   req0_rdy, 1);
      check("rst_req1_rdy",   req1_rdy, 0);
      check("rst_owner",      slot_owner, 0);
      check("rst_violation",  violation, 0);
      check("rst_resp_vals",  {resp0_val, resp1_val, memresp_rdy}, 0);
      ctl = 47'h1234_5678_9ABC; dat = 128'hDEAD_BEEF_0123_4567_89AB_CDEF_F00D_CAFE;
      req0_msg = {ctl, dat}; req0_val = 1'b1;
      #1;
      check("t1_issue", {memreq_val, memreq_domain, req0_rdy}, 3'b101);
      check("t1_ctl",   memreq_control, ctl);
      check("t1_data",  memreq_data, dat);
      @(negedge clk);
      req0_val = 1'b0;
      rctl = 17'h1A5A5; rdat = 128'h0F0F_0000_1111_2222_3333_4444_5555_6666;
      memresp_control = rctl; memresp_data = rdat;
      memresp_val = 1'b1; memresp_domain = D0; resp0_rdy = 1'b1;
      #1;
      check("t1_wait_noreq", {memreq_val, req0_rdy}, 0);
      check("t1_resp_val",   {resp0_val, resp1_val, memresp_rdy}, 3'b101);
      check("t1_resp_msg",   resp0_msg, {rctl, rdat});
      @(negedge clk);
      memresp_val = 1'b0;
      #1;
      check("t1_idle_again", req0_rdy, 1);
      check("t1_violation",  violation, 0);

      // Domain 1 held from cnt=0 of domain-0 slot
      do_reset();
      memreq_rdy = 1'b1; req1_val = 1'b1; req1_msg = {47'h7, 128'h55};
      for (int c = 0; c < 8; c++) begin
         #1;
         check($sformatf("t2_blocked_c%0d", c), {req1_rdy, memreq_val}, 0);
         @(negedge clk);
      end
      #1;
      check("t2_issue_c8", {slot_owner, memreq_val, memreq_domain, req1_rdy}, 4'b1111);
      check("t2_data", memreq_data, 128'h55);
      @(negedge clk);
      req1_val = 1'b0;
      memresp_val = 1'b1; memresp_domain = D1; resp1_rdy = 1'b1;
      #1;
      check("t2_resp", {resp1_val, resp0_val}, 2'b10);
      @(negedge clk);
      memresp_val = 1'b0;
      #1;
      check("t2_violation", violation, 0);

      // Request raised after the window closes waits for next domain-0 slot
      do_reset();
      memreq_rdy = 1'b1;
      steps(5);
      req0_val = 1'b1;
      for (int c = 5; c < 16; c++) begin
         #1;
         check($sformatf("t3_blocked_c%0d", c), {memreq_val, req0_rdy}, 0);
         @(negedge clk);
      end
      #1;
      check("t3_issue_c16", {slot_owner, memreq_val, memreq_domain, req0_rdy}, 4'b0101);

      // Issue in the last window cycle is legal
      do_reset();
      memreq_rdy = 1'b1;
      steps(4);
      req0_val = 1'b1;
      #1;
      check("t3b_last_win", {memreq_val, req0_rdy}, 2'b11);
      @(negedge clk);
      req0_val = 1'b0; memresp_val = 1'b1; resp0_rdy = 1'b1;
      #1;
      check("t3b_resp", resp0_val, 1);
      @(negedge clk);
      memresp_val = 1'b0;
      #1;
      check("t3b_violation", violation, 0);

      // Domain-0 load must not change domain-1 timing
      run_sat(1'b1, ownA, i0A, i1A, vA);
      run_sat(1'b0, ownB, i0B, i1B, vB);
      check("t4_ownA", ownA, 32'hFF00_FF00);
      check("t4_ownB", ownB, 32'hFF00_FF00);
      check("t4_iss1A", i1A, 32'h1500_1500);
      check("t4_iss1B", i1B, 32'h1500_1500);
      check("t4_iss0A", i0A, 32'h0015_0015);
      check("t4_iss0B", i0B, 32'h0);
      check("t4_viol",  {vA, vB}, 0);

      // Stalled response crosses into domain-1 slot
      do_reset();
      memreq_rdy = 1'b1; resp0_rdy = 1'b1; resp1_rdy = 1'b1;
      req0_val = 1'b1;
      @(negedge clk);
      req0_val = 1'b0;
      steps(7);
      memresp_val = 1'b1; memresp_domain = D0;
      #1;
      check("t5_late_resp", {slot_owner, resp0_val, resp1_val, violation}, 4'b1100);
      @(negedge clk);
      memresp_val = 1'b0; req1_val = 1'b1;
      #1;
      check("t5_viol_set", violation, 1);
      check("t5_d1_issue", {memreq_val, memreq_domain}, 2'b11);
      @(negedge clk);
      req1_val = 1'b0; memresp_val = 1'b1; memresp_domain = D1;
      #1;
      check("t5_d1_wait", {resp1_val, violation}, 2'b11);
      // Reset while waiting clears everything asynchronously
      reset = 1'b1;
      #1;
      check("t6_rst_wait", {resp1_val, resp0_val, memresp_rdy, memreq_val}, 0);
      check("t6_rst_state", {slot_owner, violation, req0_rdy}, 3'b001);
      memresp_val = 1'b0;
      @(negedge clk);
      reset = 1'b0;

      // Response while idle is refused and flagged
      do_reset();
      memresp_val = 1'b1;
      #1;
      check("t7_idle_resp", {memresp_rdy, resp0_val, resp1_val}, 0);
      @(negedge clk);
      memresp_val = 1'b0;
      #1;
      check("t7_viol_set", violation, 1);
      steps(3);
      #1;
      check("t7_viol_sticky", violation, 1);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

`default_nettype wire
